hex_scroll_ctrl: RTL and testbench

- Scheduler for the 6-digit HEX marquee. It holds a message of up to MSG_DEPTH 4-bit glyph codes, loaded through a valid/ready write port.
- It sequences a circular 6-digit window across the message at a programmable step rate, in either direction, with start, stop and clear control.
- Its output drives the existing per-digit glyph decoders; it never drives segments itself.

---
 rtl/hex_scroll_pkg.sv | 25 ++
 rtl/hex_scroll_ctrl_prescaler.sv | 36 +++
 rtl/hex_scroll_ctrl.sv | 132 +++++++++++++
 tb/tb_hex_scroll_ctrl.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hex_scroll_pkg.sv
// Shared types and constants for the HEX marquee scroll controller.
// Holds the controller state encoding, glyph/window sizes and the modular index helpers.
package hex_scroll_pkg;

  localparam int CODE_W = 4;
  localparam int DIGITS = 6;
  localparam int LEN_W  = 5;
  localparam logic [CODE_W-1:0] DEFAULT_BLANK = 4'h0;

  typedef enum logic [1:0] {IDLE, LOAD, ARMED, RUN} state_t;

  // Index arithmetic modulo the message length, done by compare-and-wrap.
  function automatic logic [LEN_W-1:0] wrap_inc(input logic [LEN_W-1:0] v,
                                                input logic [LEN_W-1:0] len);
    logic [LEN_W-1:0] n;
    n = v + LEN_W'(1);
    return (n == len) ? '0 : n;
  endfunction

  function automatic logic [LEN_W-1:0] wrap_dec(input logic [LEN_W-1:0] v,
                                                input logic [LEN_W-1:0] len);
    return (v == '0) ? len - LEN_W'(1) : v - LEN_W'(1);
  endfunction

endpackage

// File: rtl/hex_scroll_ctrl_prescaler.sv
// Step-rate prescaler: counts enabled cycles and pulses once every (TICK_DIV >> speed) cycles.
// A shortened period takes effect immediately; an already-overshot count fires at once.
module scroll_prescaler #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic [1:0] speed_i,
  output logic       step_o
);

  localparam int CNT_W = $clog2(TICK_DIV + 1);
  localparam logic [CNT_W-1:0] TDIV = CNT_W'(TICK_DIV);

  logic [CNT_W-1:0] cnt_q, cnt_d, limit;

  assign limit  = TDIV >> speed_i;
  assign step_o = en_i && (cnt_q >= limit - CNT_W'(1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i)
      cnt_d = step_o ? '0 : cnt_q + CNT_W'(1);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/hex_scroll_ctrl.sv
// 6-digit HEX marquee scheduler: stores a glyph message and rotates a circular window over it.
// The codes output feeds the per-digit glyph decoders; no segment logic lives here.
module hex_scroll_ctrl
  import hex_scroll_pkg::*;
#(
  parameter int TICK_DIV  = 50_000_000,
  parameter int MSG_DEPTH = 16,
  parameter logic [CODE_W-1:0] BLANK = DEFAULT_BLANK
) (
  input  logic                     CLOCK_50,
  input  logic                     reset,
  input  logic                     wr_valid,
  input  logic [CODE_W-1:0]        wr_code,
  input  logic                     wr_last,
  output logic                     wr_ready,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     clear,
  input  logic                     dir,
  input  logic [1:0]               speed,
  output logic                     busy,
  output logic                     step,
  output logic [LEN_W-1:0]         msg_len,
  output logic [CODE_W*DIGITS-1:0] codes
);

  localparam int AW = $clog2(MSG_DEPTH);

  state_t                    state_q, state_d;
  logic [LEN_W-1:0]          wr_ptr_q, wr_ptr_d;
  logic [LEN_W-1:0]          head_q, head_d;
  logic [LEN_W-1:0]          len_q, len_d;
  logic [CODE_W*DIGITS-1:0]  codes_q, codes_d;
  logic [CODE_W-1:0]         msg_mem_q [MSG_DEPTH];
  logic                      wr_fire, go, run_en, step_w;

  assign wr_ready = (state_q == IDLE) || (state_q == LOAD);
  assign wr_fire  = wr_valid && wr_ready && !clear;
  assign go       = (state_q == ARMED) && start && !stop && !clear;
  assign run_en   = (state_q == RUN) && !stop && !clear;

  scroll_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk     (CLOCK_50),
    .rst     (reset),
    .clr_i   (go || clear),
    .en_i    (run_en),
    .speed_i (speed),
    .step_o  (step_w)
  );

  assign step    = step_w;
  assign busy    = (state_q == RUN);
  assign msg_len = len_q;
  assign codes   = codes_q;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    head_d   = head_q;
    len_d    = len_q;
    if (clear) begin
      state_d  = IDLE;
      wr_ptr_d = '0;
      head_d   = '0;
      len_d    = '0;
    end else begin
      case (state_q)
        IDLE: if (wr_fire) begin
          wr_ptr_d = LEN_W'(1);
          if (wr_last) begin
            len_d   = LEN_W'(1);
            state_d = ARMED;
          end else begin
            state_d = LOAD;
          end
        end
        LOAD: if (wr_fire) begin
          wr_ptr_d = wr_ptr_q + LEN_W'(1);
          if (wr_last || wr_ptr_q == LEN_W'(MSG_DEPTH - 1)) begin
            len_d   = wr_ptr_q + LEN_W'(1);
            head_d  = '0;
            state_d = ARMED;
          end
        end
        ARMED: if (go) state_d = RUN;
        RUN: begin
          if (stop)
            state_d = ARMED;
          else if (step_w)
            head_d = dir ? wrap_dec(head_q, len_q) : wrap_inc(head_q, len_q);
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Window: leftmost digit shows buf[head], each digit to the right the next code, wrapping.
  always_comb begin : window_mux
    logic [LEN_W-1:0] p;
    p       = head_q;
    codes_d = {DIGITS{BLANK}};
    if (!clear && (state_q == ARMED || state_q == RUN)) begin
      for (int k = DIGITS - 1; k >= 0; k--) begin
        codes_d[k*CODE_W +: CODE_W] = msg_mem_q[p[AW-1:0]];
        p = wrap_inc(p, len_q);
      end
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      head_q   <= '0;
      len_q    <= '0;
      codes_q  <= {DIGITS{BLANK}};
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      head_q   <= head_d;
      len_q    <= len_d;
      codes_q  <= codes_d;
    end
  end

  // NOTE: message storage is not reset; stale entries are never shown because msg_len gates the window.
  always_ff @(posedge CLOCK_50) begin
    if (wr_fire) msg_mem_q[wr_ptr_q[AW-1:0]] <= wr_code;
  end

endmodule

// File: tb/tb_hex_scroll_ctrl.sv
// Self-checking bench for hex_scroll_ctrl: a cycle-level message/window model compared every cycle,
// plus directed scenarios with hand-computed window values.
module tb_hex_scroll_ctrl;

  localparam int TICK_DIV  = 8;
  localparam int MSG_DEPTH = 16;

  logic        clk;
  logic        reset;
  logic        wr_valid, wr_last, wr_ready;
  logic [3:0]  wr_code;
  logic        start, stop, clear, dir;
  logic [1:0]  speed;
  logic        busy, step;
  logic [4:0]  msg_len;
  logic [23:0] codes;

  int checks = 0;
  int errors = 0;

  hex_scroll_ctrl #(.TICK_DIV(TICK_DIV), .MSG_DEPTH(MSG_DEPTH), .BLANK(4'h0)) dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .wr_valid (wr_valid),
    .wr_code  (wr_code),
    .wr_last  (wr_last),
    .wr_ready (wr_ready),
    .start    (start),
    .stop     (stop),
    .clear    (clear),
    .dir      (dir),
    .speed    (speed),
    .busy     (busy),
    .step     (step),
    .msg_len  (msg_len),
    .codes    (codes)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // mode: 0 empty, 1 receiving, 2 paused with message, 3 scrolling
  logic [3:0]  mm [MSG_DEPTH];
  int          m_mode = 0, m_cnt = 0, m_len = 0, m_head = 0, m_elapsed = 0;
  logic [23:0] m_codes = 24'h0;

  function automatic logic [23:0] model_window();
    logic [23:0] w;
    w = '0;
    for (int k = 0; k < 6; k++) w[k*4 +: 4] = mm[(m_head + 5 - k) % m_len];
    return w;
  endfunction

  function automatic logic model_step();
    return (m_mode == 3) && !stop && !clear && (m_elapsed >= (TICK_DIV >> speed) - 1);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_mode = 0; m_cnt = 0; m_len = 0; m_head = 0; m_elapsed = 0; m_codes = 24'h0;
    end else begin
      logic [23:0] nxt;
      logic        st;
      nxt = (!clear && m_mode >= 2) ? model_window() : 24'h0;
      st  = model_step();
      if (clear) begin
        m_mode = 0; m_cnt = 0; m_len = 0; m_head = 0;
      end else begin
        case (m_mode)
          0, 1: if (wr_valid) begin
            mm[m_cnt] = wr_code;
            m_cnt++;
            if (wr_last || m_cnt == MSG_DEPTH) begin
              m_len = m_cnt; m_head = 0; m_mode = 2;
            end else begin
              m_mode = 1;
            end
          end
          2: if (start && !stop) begin m_mode = 3; m_elapsed = 0; end
          3: begin
            if (stop) m_mode = 2;
            else if (st) begin
              m_elapsed = 0;
              m_head = dir ? (m_head + m_len - 1) % m_len : (m_head + 1) % m_len;
            end else m_elapsed++;
          end
          default: m_mode = 0;
        endcase
      end
      m_codes = nxt;
    end
  end

  initial begin
    @(posedge reset);
    forever begin
      @(negedge clk);
      check("codes",    codes,    m_codes);
      check("busy",     busy,     m_mode == 3);
      check("wr_ready", wr_ready, m_mode <= 1);
      check("msg_len",  msg_len,  m_len);
      check("step",     step,     model_step());
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_code(input logic [3:0] c, input logic last);
    wr_valid = 1'b1; wr_code = c; wr_last = last;
    tick();
    wr_valid = 1'b0; wr_last = 1'b0;
  endtask

  task automatic pulse(input int which);
    if (which == 0) start = 1'b1; else if (which == 1) stop = 1'b1; else clear = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0; clear = 1'b0;
  endtask

  task automatic wait_step(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!step && n < 64);
    check("step_seen", step, 1'b1);
  endtask

  task automatic stop_after_step();
    @(posedge clk);
    #1;
    pulse(1);
  endtask

  initial begin
    int n;
    reset = 1'b0; wr_valid = 1'b0; wr_code = 4'h0; wr_last = 1'b0;
    start = 1'b0; stop = 1'b0; clear = 1'b0; dir = 1'b0; speed = 2'd0;
    #2 reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    @(negedge clk);
    check("rst_codes", codes, 24'h000000);
    check("rst_len", msg_len, 0);
    check("rst_ready", wr_ready, 1'b1);
    check("rst_busy", busy, 1'b0);

    // 6-code message 0,0,0,D,E,1
    tick();
    write_code(4'h0, 0); write_code(4'h0, 0); write_code(4'h0, 0);
    write_code(4'hD, 0); write_code(4'hE, 0); write_code(4'h1, 1);
    tick();
    @(negedge clk);
    check("armed_codes", codes, 24'h000DE1);
    check("armed_len", msg_len, 6);
    check("armed_ready", wr_ready, 1'b0);

    // rotate left at full period
    tick();
    pulse(0);
    wait_step(n);
    check("period8", n, 8);
    repeat (2) @(negedge clk);
    check("left1", codes, 24'h00DE10);
    wait_step(n); repeat (2) @(negedge clk);
    check("left2", codes, 24'h0DE100);
    wait_step(n); repeat (2) @(negedge clk);
    check("left3", codes, 24'hDE1000);
    wait_step(n); wait_step(n); wait_step(n);
    check("period8b", n, 8);
    stop_after_step();
    @(negedge clk);
    check("left6", codes, 24'h000DE1);
    check("paused_busy", busy, 1'b0);

    // rotate right at half period, pause after two steps
    dir = 1'b1; speed = 2'd1;
    tick();
    pulse(0);
    wait_step(n);
    check("period4", n, 4);
    repeat (2) @(negedge clk);
    check("right1", codes, 24'h1000DE);
    wait_step(n);
    stop_after_step();
    @(negedge clk);
    check("right2", codes, 24'hE1000D);
    check("stop_busy", busy, 1'b0);
    repeat (10) @(negedge clk);
    check("hold", codes, 24'hE1000D);

    // clear, then fill the buffer without wr_last
    tick();
    pulse(2);
    @(negedge clk);
    check("clr_codes", codes, 24'h000000);
    check("clr_len", msg_len, 0);
    tick();
    for (int i = 0; i < 16; i++) write_code(4'((i + 1) % 16), 0);
    @(negedge clk);
    check("full_ready", wr_ready, 1'b0);
    check("full_len", msg_len, 16);
    @(negedge clk);
    check("full_codes", codes, 24'h123456);

    // step every cycle to the right across the 15->0 wrap, then speed changes mid-count
    dir = 1'b1; speed = 2'd3;
    tick();
    pulse(0);
    repeat (3) @(negedge clk);
    check("fast_wrap", codes, 24'h012345);
    tick();
    dir = 1'b0; speed = 2'd0;
    repeat (6) tick();
    speed = 2'd1;
    repeat (12) tick();

    // clear and start together
    clear = 1'b1; start = 1'b1;
    tick();
    clear = 1'b0; start = 1'b0;
    @(negedge clk);
    check("cs_codes", codes, 24'h000000);
    check("cs_busy", busy, 1'b0);
    check("cs_len", msg_len, 0);

    // single-code message
    tick();
    write_code(4'hE, 1);
    tick();
    pulse(0);
    wait_step(n);
    wait_step(n);
    repeat (2) @(negedge clk);
    check("single_codes", codes, 24'hEEEEEE);
    check("single_len", msg_len, 1);
    check("single_busy", busy, 1'b1);

    // asynchronous reset while scrolling
    @(posedge clk);
    #3 reset = 1'b1;
    @(negedge clk);
    check("mid_rst_codes", codes, 24'h000000);
    check("mid_rst_len", msg_len, 0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_ready", wr_ready, 1'b1);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (4) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation did not complete");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
